// File: rtl/mpsk_modulator.sv
// BPSK / Gray-coded QPSK carrier modulator: serial bits in, offset-binary DAC samples out.
// Phase accumulator runs continuously across symbols; the symbol rotates the sine LUT by quadrants.
module mpsk_modulator #(
  parameter int DAC_W        = 16,
  parameter int PHASE_W      = 8,
  parameter int STEP         = 16,
  parameter int SAMP_PER_SYM = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             bit_data,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [DAC_W-1:0] samp_data,
  output logic             samp_valid,
  input  logic             samp_ready,
  output logic             sym_strobe,
  output logic             busy,
  output logic             underrun
);

  localparam int  LUT_N = 1 << PHASE_W;
  localparam int  MID   = 1 << (DAC_W - 1);
  localparam int  CNT_W = $clog2(SAMP_PER_SYM + 1);
  localparam real PI    = 3.14159265358979323846;
  localparam logic [DAC_W-1:0] MID_V = {1'b1, {(DAC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN, PARK} state_t;

  // Sine table, rounded half away from zero, centred on midscale.
  logic [DAC_W-1:0] rom [LUT_N];
  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_rom
    localparam real S = real'(MID - 1) * $sin(2.0 * PI * real'(gi) / real'(LUT_N));
    localparam int  V = MID + ((S >= 0.0) ? $rtoi(S + 0.5) : -$rtoi(0.5 - S));
    assign rom[gi] = DAC_W'(V);
  end

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               bit_cnt_q, bit_cnt_d;
  logic               first_bit_q, first_bit_d;
  logic               mode_q, mode_d;
  logic [1:0]         quad_q, quad_d;
  logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic [DAC_W-1:0]   samp_data_q, samp_data_d;
  logic               samp_valid_q, samp_valid_d;
  logic               sym_strobe_q, sym_strobe_d;
  logic               underrun_q, underrun_d;
  logic               first_load_q, first_load_d;

  logic               bit_xfer, samp_xfer, mode_eff;
  logic [1:0]         quad_new;
  logic [PHASE_W-1:0] phase_inc, load_idx, run_idx;

  assign bit_ready  = (state_q == LOAD) && (en || bit_cnt_q);
  assign bit_xfer   = bit_valid && bit_ready;
  assign samp_xfer  = samp_valid_q && samp_ready;
  assign samp_data  = samp_data_q;
  assign samp_valid = samp_valid_q;
  assign sym_strobe = sym_strobe_q;
  assign underrun   = underrun_q;
  assign busy       = (state_q != IDLE);

  // Mode is taken live on the first bit of a symbol, then held for its second bit.
  assign mode_eff  = bit_cnt_q ? mode_q : mode;
  assign quad_new  = mode_eff ? {first_bit_q, first_bit_q ^ bit_data} : {bit_data, 1'b0};
  assign phase_inc = phase_q + PHASE_W'(STEP);
  assign load_idx  = phase_q + {quad_new, {(PHASE_W-2){1'b0}}};
  assign run_idx   = phase_inc + {quad_q, {(PHASE_W-2){1'b0}}};

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    first_bit_d  = first_bit_q;
    mode_d       = mode_q;
    quad_d       = quad_q;
    samp_cnt_d   = samp_cnt_q;
    samp_data_d  = samp_data_q;
    samp_valid_d = samp_valid_q;
    sym_strobe_d = 1'b0;
    underrun_d   = underrun_q;
    first_load_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = LOAD;
          phase_d   = '0;
          bit_cnt_d = 1'b0;
        end
      end
      LOAD: begin
        if (first_load_q && en && !bit_valid) underrun_d = 1'b1;
        if (!bit_cnt_q && !en) begin
          state_d      = PARK;
          samp_data_d  = MID_V;
          samp_valid_d = 1'b1;
        end else if (bit_xfer) begin
          if (!mode_eff || bit_cnt_q) begin
            state_d      = RUN;
            quad_d       = quad_new;
            sym_strobe_d = 1'b1;
            bit_cnt_d    = 1'b0;
            samp_cnt_d   = '0;
            samp_data_d  = rom[load_idx];
            samp_valid_d = 1'b1;
          end else begin
            bit_cnt_d   = 1'b1;
            first_bit_d = bit_data;
            mode_d      = mode;
          end
        end
      end
      RUN: begin
        if (samp_xfer) begin
          phase_d = phase_inc;
          if (samp_cnt_q == CNT_W'(SAMP_PER_SYM - 1)) begin
            state_d      = LOAD;
            samp_cnt_d   = '0;
            samp_valid_d = 1'b0;
            first_load_d = 1'b1;
          end else begin
            samp_cnt_d  = samp_cnt_q + 1'b1;
            samp_data_d = rom[run_idx];
          end
        end
      end
      PARK: begin
        if (samp_xfer) begin
          state_d      = IDLE;
          samp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      bit_cnt_q    <= 1'b0;
      first_bit_q  <= 1'b0;
      mode_q       <= 1'b0;
      quad_q       <= 2'd0;
      samp_cnt_q   <= '0;
      samp_data_q  <= MID_V;
      samp_valid_q <= 1'b0;
      sym_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;
      first_load_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      first_bit_q  <= first_bit_d;
      mode_q       <= mode_d;
      quad_q       <= quad_d;
      samp_cnt_q   <= samp_cnt_d;
      samp_data_q  <= samp_data_d;
      samp_valid_q <= samp_valid_d;
      sym_strobe_q <= sym_strobe_d;
      underrun_q   <= underrun_d;
      first_load_q <= first_load_d;
    end
  end

endmodule

// File: tb/tb_mpsk_modulator.sv
// Directed bench for mpsk_modulator at default parameters (STEP=16, so every LUT index is a multiple of 16).
module tb_mpsk_modulator;

  logic        clk = 1'b0;
  logic        rst, en, mode, bit_data, bit_valid, samp_ready;
  logic        bit_ready, samp_valid, sym_strobe, busy, underrun;
  logic [15:0] samp_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobe = 0;
  int ph = 0;
  int s0;

  // Hand-computed 32768 + round(32767*sin(2*pi*16k/256)), k = 0..15.
  int tbl [16] = '{32768, 45307, 55938, 63041, 65535, 63041, 55938, 45307,
                   32768, 20229,  9598,  2495,     1,  2495,  9598, 20229};

  mpsk_modulator dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .bit_data   (bit_data),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .samp_data  (samp_data),
    .samp_valid (samp_valid),
    .samp_ready (samp_ready),
    .sym_strobe (sym_strobe),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sym_strobe) n_strobe++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    int t = 0;
    bit_data  = b;
    bit_valid = 1'b1;
    while (!bit_ready && t < 40) begin
      step();
      t++;
    end
    chk("bit_ready", 32'(bit_ready), 1);
    step();
    bit_valid = 1'b0;
  endtask

  task automatic get_samp(input int exp, input string tag);
    int t = 0;
    while (!(samp_valid && samp_ready) && t < 40) begin
      step();
      t++;
    end
    chk({tag, "_vld"}, 32'(samp_valid), 1);
    chk(tag, 32'(samp_data), exp);
    step();
  endtask

  // One full symbol at quadrant q; optionally stall the DAC for 5 cycles before sample stall_at.
  task automatic do_sym(input int q, input int stall_at, input string tag);
    for (int k = 0; k < 16; k++) begin
      if (k == stall_at) begin
        samp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          chk($sformatf("%s_stall_vld%0d", tag, i), 32'(samp_valid), 1);
          chk($sformatf("%s_stall_dat%0d", tag, i), 32'(samp_data), tbl[(ph + 4*q) % 16]);
          step();
        end
        samp_ready = 1'b1;
      end
      get_samp(tbl[(ph + 4*q) % 16], $sformatf("%s_s%0d", tag, k));
      ph = (ph + 1) % 16;
    end
    chk({tag, "_end_vld"}, 32'(samp_valid), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; bit_data = 1'b0; bit_valid = 1'b0; samp_ready = 1'b1;
    repeat (3) step();
    chk("rst_vld",   32'(samp_valid), 0);
    chk("rst_data",  32'(samp_data),  32768);
    chk("rst_rdy",   32'(bit_ready),  0);
    chk("rst_busy",  32'(busy),       0);
    chk("rst_urun",  32'(underrun),   0);
    chk("rst_strb",  32'(sym_strobe), 0);
    rst = 1'b0;
    step();

    // BPSK bits 0 then 1
    en = 1'b1; mode = 1'b0; ph = 0;
    s0 = n_strobe;
    send_bit(1'b0);
    do_sym(0, -1, "bpsk0");
    send_bit(1'b1);
    do_sym(2, -1, "bpsk1");
    chk("bpsk_strobes", 32'(n_strobe - s0), 2);
    chk("bpsk_urun", 32'(underrun), 0);

    // QPSK 01, 11, 10
    mode = 1'b1;
    s0 = n_strobe;
    send_bit(1'b0); send_bit(1'b1);
    do_sym(1, -1, "qpsk01");
    send_bit(1'b1); send_bit(1'b1);
    do_sym(2, -1, "qpsk11");
    send_bit(1'b1); send_bit(1'b0);
    do_sym(3, -1, "qpsk10");
    chk("qpsk_strobes", 32'(n_strobe - s0), 3);

    // Backpressure mid-symbol
    mode = 1'b0;
    send_bit(1'b0);
    do_sym(0, 5, "bp");
    chk("bp_urun", 32'(underrun), 0);

    // Underrun: starve the bit source after a symbol
    send_bit(1'b1);
    do_sym(2, -1, "pre_ur");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ur_novld%0d", i), 32'(samp_valid), 0);
      step();
    end
    chk("ur_set", 32'(underrun), 1);
    send_bit(1'b0);
    do_sym(0, -1, "post_ur");
    chk("ur_sticky", 32'(underrun), 1);

    // Stop after the first QPSK bit
    mode = 1'b1;
    send_bit(1'b1);
    en = 1'b0;
    send_bit(1'b0);
    do_sym(3, -1, "stop");
    get_samp(32768, "park");
    chk("park_busy", 32'(busy), 0);
    chk("park_vld", 32'(samp_valid), 0);
    step();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rdy", 32'(bit_ready), 0);

    // Reset during RUN
    en = 1'b1; mode = 1'b0; ph = 0;
    send_bit(1'b1);
    for (int k = 0; k < 3; k++) begin
      get_samp(tbl[(k + 8) % 16], $sformatf("prerst_s%0d", k));
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mrst_vld%0d", i),  32'(samp_valid), 0);
      chk($sformatf("mrst_data%0d", i), 32'(samp_data),  32768);
      chk($sformatf("mrst_rdy%0d", i),  32'(bit_ready),  0);
      chk($sformatf("mrst_busy%0d", i), 32'(busy),       0);
      chk($sformatf("mrst_urun%0d", i), 32'(underrun),   0);
    end
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
